voice_table_sweeper: RTL and testbench

- Port-B reader of the voice-parameter true dual-port RAM; the MIDI parser writes that RAM on port A.
- On each sample tick, sweeps every voice address, reads {gate, increment}, and advances a per-voice phase accumulator held in local registers.
- Sums one square-wave contribution per gated voice and presents one mixed sample per tick to the output DAC path.

---
 rtl/voice_table_sweeper_pkg.sv | 22 ++
 rtl/voice_table_sweeper_if.sv | 13 +
 rtl/voice_table_sweeper_phase_bank.sv | 29 ++
 rtl/voice_table_sweeper.sv | 113 +++++++++++
 tb/tb_voice_table_sweeper.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/voice_table_sweeper_pkg.sv
// Shared definitions for the voice table sweeper: FSM encoding, RAM word
// field positions and the per-voice square-wave amplitude.
package voice_table_sweeper_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Gate sits directly above the increment field in each RAM word.
  function automatic int gate_bit(int inc_w);
    return inc_w;
  endfunction

  // Largest amplitude for which N voices summed can never overflow OUT_WIDTH.
  function automatic int amp_of(int out_w, int addr_w);
    return (1 << (out_w - 1 - addr_w)) - 1;
  endfunction

endpackage

// File: rtl/voice_table_sweeper_if.sv
// Port-B bus of the voice-parameter dual-port RAM.
interface voice_table_sweeper_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int INC_WIDTH  = 16
);
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic                  ram_we;
  logic [INC_WIDTH:0]    ram_din;
  logic [INC_WIDTH:0]    ram_dout;

  modport master (output ram_addr, output ram_we, output ram_din, input ram_dout);
  modport slave  (input ram_addr, input ram_we, input ram_din, output ram_dout);
endinterface

// File: rtl/voice_table_sweeper_phase_bank.sv
// Per-voice phase accumulators; combinational read so the returning RAM word
// can be processed in the same clock it arrives.
module voice_table_sweeper_phase_bank #(
  parameter int ADDR_WIDTH  = 4,
  parameter int PHASE_WIDTH = 24
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADDR_WIDTH-1:0]  rd_idx,
  output logic [PHASE_WIDTH-1:0] rd_phase,
  input  logic                   we,
  input  logic [ADDR_WIDTH-1:0]  wr_idx,
  input  logic [PHASE_WIDTH-1:0] wr_phase
);
  localparam int N = 1 << ADDR_WIDTH;

  logic [PHASE_WIDTH-1:0] phase_q [N];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) phase_q[i] <= '0;
    end else if (we) begin
      phase_q[wr_idx] <= wr_phase;
    end
  end

  assign rd_phase = phase_q[rd_idx];

endmodule

// File: rtl/voice_table_sweeper.sv
// Sweeps the voice table on each sample tick, advances every voice phase and
// emits one mixed square-wave sample per tick.
//
// state | meaning
// IDLE  | waiting for tick
// SWEEP | issuing addresses 0..N-1, processing the word of the previous address
// DRAIN | processing the word of voice N-1
// DONE  | publishing the accumulated mix
module voice_table_sweeper
  import voice_table_sweeper_pkg::*;
#(
  parameter int ADDR_WIDTH  = 4,
  parameter int INC_WIDTH   = 16,
  parameter int PHASE_WIDTH = 24,
  parameter int OUT_WIDTH   = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        tick,
  voice_table_sweeper_if.master       ram,
  output logic signed [OUT_WIDTH-1:0] mix_out,
  output logic                        mix_valid,
  output logic                        busy,
  output logic                        overrun
);
  localparam int N    = 1 << ADDR_WIDTH;
  localparam int GATE = gate_bit(INC_WIDTH);
  localparam logic signed [OUT_WIDTH-1:0] AMP = OUT_WIDTH'(amp_of(OUT_WIDTH, ADDR_WIDTH));
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(N - 1);

  state_t                       state_q, state_d;
  logic [ADDR_WIDTH-1:0]        addr_q, idx_q;
  logic                         valid_q;
  logic signed [OUT_WIDTH-1:0]  acc_q;
  logic [PHASE_WIDTH-1:0]       cur_phase, new_phase;
  logic signed [OUT_WIDTH-1:0]  contrib;
  logic                         gate;

  assign ram.ram_addr = addr_q;
  assign ram.ram_we   = 1'b0;
  assign ram.ram_din  = '0;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (tick) state_d = ST_SWEEP;
      ST_SWEEP: if (addr_q == LAST_ADDR) state_d = ST_DRAIN;
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    gate      = ram.ram_dout[GATE];
    new_phase = '0;
    contrib   = '0;
    if (gate) begin
      new_phase = cur_phase + PHASE_WIDTH'(ram.ram_dout[INC_WIDTH-1:0]);
      contrib   = new_phase[PHASE_WIDTH-1] ? AMP : -AMP;
    end
  end

  // idx_q lags addr_q by one clock to line up with the registered RAM output.
  voice_table_sweeper_phase_bank #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .PHASE_WIDTH(PHASE_WIDTH)
  ) u_bank (
    .clk     (clk),
    .rst     (rst),
    .rd_idx  (idx_q),
    .rd_phase(cur_phase),
    .we      (valid_q),
    .wr_idx  (idx_q),
    .wr_phase(new_phase)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      acc_q     <= '0;
      mix_out   <= '0;
      mix_valid <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= addr_q;
      valid_q   <= (state_q == ST_SWEEP);
      overrun   <= tick && (state_q != ST_IDLE);
      mix_valid <= 1'b0;
      if (valid_q) acc_q <= acc_q + contrib;
      case (state_q)
        ST_IDLE: if (tick) begin
          addr_q <= '0;
          acc_q  <= '0;
          busy   <= 1'b1;
        end
        ST_SWEEP: if (addr_q != LAST_ADDR) addr_q <= addr_q + 1'b1;
        ST_DONE: begin
          mix_out   <= acc_q;
          mix_valid <= 1'b1;
          busy      <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_voice_table_sweeper.sv
// Directed bench for voice_table_sweeper: table of per-tick RAM contents with
// expected mix and phases, plus overrun and mid-sweep reset sequences.
module tb_voice_table_sweeper;
  localparam int N = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick = 1'b0;
  always #5 clk = ~clk;

  voice_table_sweeper_if #(.ADDR_WIDTH(4), .INC_WIDTH(16)) ram_bus ();

  logic signed [15:0] mix_out;
  logic               mix_valid, busy, overrun;

  voice_table_sweeper #(
    .ADDR_WIDTH(4), .INC_WIDTH(16), .PHASE_WIDTH(24), .OUT_WIDTH(16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .ram      (ram_bus),
    .mix_out  (mix_out),
    .mix_valid(mix_valid),
    .busy     (busy),
    .overrun  (overrun)
  );

  // Port-B side of the RAM model: registered read, one clock latency.
  logic [16:0] mem [N];
  always @(posedge clk) ram_bus.ram_dout <= mem[ram_bus.ram_addr];

  logic we_seen = 1'b0;
  always @(posedge clk)
    if (ram_bus.ram_we !== 1'b0 || ram_bus.ram_din !== 17'd0) we_seen <= 1'b1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  typedef struct {
    logic [15:0] gate_mask;
    logic [15:0] inc_v0;
    logic [15:0] inc_rest;
    int          reps;
    int          exp_mix;
    int          exp_ph0;
    int          exp_ph3;
    int          exp_ph15;
  } vec_t;

  vec_t vecs [12];

  task automatic load_mem(input logic [15:0] gmask, input logic [15:0] inc0, input logic [15:0] incr);
    for (int i = 0; i < N; i++) mem[i] = {gmask[i], (i == 0) ? inc0 : incr};
  endtask

  task automatic do_tick(output int lat);
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    lat = 0;
    while (mix_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  int lat, n_ovr, n_val, first_val;

  initial begin
    vecs[0]  = '{16'h0000, 16'h0000, 16'h0000,   1,      0, 24'h000000, 24'h000000, 24'h000000};
    vecs[1]  = '{16'h0008, 16'h0000, 16'h4000,   1,  -2047, 24'h000000, 24'h004000, 24'h000000};
    vecs[2]  = '{16'h0008, 16'h0000, 16'h4000,   1,  -2047, 24'h000000, 24'h008000, 24'h000000};
    vecs[3]  = '{16'h0008, 16'h0000, 16'h4000,   1,  -2047, 24'h000000, 24'h00C000, 24'h000000};
    vecs[4]  = '{16'h0008, 16'h0000, 16'h4000,   1,  -2047, 24'h000000, 24'h010000, 24'h000000};
    vecs[5]  = '{16'hFFFF, 16'h8000, 16'h8000,   1, -32752, 24'h008000, 24'h018000, 24'h008000};
    vecs[6]  = '{16'hFFFF, 16'h8000, 16'h8000, 255,  32752, 24'h800000, 24'h810000, 24'h800000};
    vecs[7]  = '{16'h0000, 16'h0000, 16'h0000,   1,      0, 24'h000000, 24'h000000, 24'h000000};
    vecs[8]  = '{16'h0001, 16'hFFFF, 16'h0000, 256,   2047, 24'hFFFF00, 24'h000000, 24'h000000};
    vecs[9]  = '{16'h0001, 16'h00F0, 16'h0000,   1,   2047, 24'hFFFFF0, 24'h000000, 24'h000000};
    vecs[10] = '{16'h0001, 16'hFFFF, 16'h0000,   1,  -2047, 24'h00FFEF, 24'h000000, 24'h000000};
    vecs[11] = '{16'h0000, 16'h0000, 16'h0000,   1,      0, 24'h000000, 24'h000000, 24'h000000};

    load_mem(16'h0000, 16'h0000, 16'h0000);
    repeat (2) @(negedge clk);
    check("reset_mix_out",   int'(mix_out), 0);
    check("reset_mix_valid", int'(mix_valid), 0);
    check("reset_busy",      int'(busy), 0);
    check("reset_overrun",   int'(overrun), 0);
    check("reset_ram_addr",  int'(ram_bus.ram_addr), 0);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 12; v++) begin
      load_mem(vecs[v].gate_mask, vecs[v].inc_v0, vecs[v].inc_rest);
      for (int r = 0; r < vecs[v].reps; r++) do_tick(lat);
      check($sformatf("vec%0d_latency", v), lat, 18);
      check($sformatf("vec%0d_mix", v), int'(mix_out), vecs[v].exp_mix);
      check($sformatf("vec%0d_phase0", v), int'(dut.u_bank.phase_q[0]), vecs[v].exp_ph0);
      check($sformatf("vec%0d_phase3", v), int'(dut.u_bank.phase_q[3]), vecs[v].exp_ph3);
      check($sformatf("vec%0d_phase15", v), int'(dut.u_bank.phase_q[15]), vecs[v].exp_ph15);
    end

    // Second tick 5 clocks into a sweep: one overrun, one result, latency unchanged.
    load_mem(16'h0008, 16'h0000, 16'h4000);
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    n_ovr = 0; n_val = 0; first_val = -1;
    for (int k = 0; k < 25; k++) begin
      if (overrun) n_ovr++;
      if (mix_valid) begin
        n_val++;
        if (first_val < 0) first_val = k;
      end
      tick = (k == 4);
      @(negedge clk);
    end
    check("ovr_pulses",      n_ovr, 1);
    check("ovr_valid_count", n_val, 1);
    check("ovr_latency",     first_val, 18);
    check("ovr_mix",         int'(mix_out), -2047);
    check("ovr_phase3",      int'(dut.u_bank.phase_q[3]), 24'h004000);

    // Reset in the middle of a sweep.
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    repeat (7) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_busy",     int'(busy), 0);
    check("midrst_ram_addr", int'(ram_bus.ram_addr), 0);
    check("midrst_mix_out",  int'(mix_out), 0);
    check("midrst_phase3",   int'(dut.u_bank.phase_q[3]), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n_val = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (mix_valid) n_val++;
    end
    check("midrst_no_valid", n_val, 0);
    do_tick(lat);
    check("postrst_latency", lat, 18);
    check("postrst_mix",     int'(mix_out), -2047);
    check("postrst_phase3",  int'(dut.u_bank.phase_q[3]), 24'h004000);

    check("ram_we_never_set", int'(we_seen), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
